// File: rtl/mp2_mem_responder.sv
// Single-port memory responder for the multicycle RV32I datapath.
// Completes a read or byte-enabled write LATENCY cycles after the request and pulses mem_resp.
module mp2_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_address,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [3:0]  mem_byte_enable,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_resp,
    output logic        mem_err
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        r_state, w_next;
    logic [CW-1:0] r_cnt, w_cnt_next;
    logic          w_capture;

    logic [31:0]   r_addr, r_wdata;
    logic [3:0]    r_be;
    logic          r_rd, r_wr;
    logic [31:0]   r_rdata;
    logic          r_resp, r_err;

    logic [31:0]   w_addr, w_wdata;
    logic [3:0]    w_be;
    logic          w_rd, w_wr;
    logic          w_enter, w_oor, w_err_cond, w_do_read, w_do_write;
    logic [AW-1:0] w_idx;
    logic          w_unused;

    logic [31:0]   r_mem [DEPTH_WORDS];

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_capture  = 1'b0;
        case (r_state)
            IDLE: begin
                if (mem_read || mem_write) begin
                    w_capture  = 1'b1;
                    w_cnt_next = CW'(LATENCY - 1);
                    w_next     = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (r_cnt == CW'(1)) w_next = RESP;
                else                 w_cnt_next = r_cnt - CW'(1);
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // With LATENCY==1 the edge into RESP is also the capture edge, so use the live inputs then.
    assign w_addr  = w_capture ? mem_address     : r_addr;
    assign w_wdata = w_capture ? mem_wdata       : r_wdata;
    assign w_be    = w_capture ? mem_byte_enable : r_be;
    assign w_rd    = w_capture ? mem_read        : r_rd;
    assign w_wr    = w_capture ? mem_write       : r_wr;

    assign w_enter    = (w_next == RESP) && (r_state != RESP);
    assign w_oor      = |(w_addr >> (AW + 2));
    assign w_idx      = w_addr[AW+1:2];
    assign w_err_cond = w_oor || (w_rd && w_wr);
    assign w_do_read  = w_enter && w_rd && !w_wr;
    assign w_do_write = w_enter && w_wr && !w_oor;
    assign w_unused   = ^w_addr[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_resp  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            r_resp  <= w_enter;
            r_err   <= w_enter && w_err_cond;
            if (w_capture) begin
                r_addr  <= mem_address;
                r_wdata <= mem_wdata;
                r_be    <= mem_byte_enable;
                r_rd    <= mem_read;
                r_wr    <= mem_write;
            end
            if (w_do_read) r_rdata <= w_oor ? 32'h0 : r_mem[w_idx];
        end
    end

    // Backing array has no reset so it maps onto block RAM and survives rst.
    always_ff @(posedge clk) begin
        if (!rst && w_do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
            end
        end
    end

    assign mem_rdata = r_rdata;
    assign mem_resp  = r_resp;
    assign mem_err   = r_err;
endmodule

// File: tb/tb_mp2_mem_responder.sv
// Directed bench for mp2_mem_responder: LATENCY=3 main instance plus a LATENCY=1 instance.
module tb_mp2_mem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0, wd = '0, rdata;
    logic        rd = 1'b0, wr = 1'b0, resp, err;
    logic [3:0]  be = '0;

    logic [31:0] addr1 = '0, wd1 = '0, rdata1;
    logic        rd1 = 1'b0, wr1 = 1'b0, resp1, err1;
    logic [3:0]  be1 = '0;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mp2_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(3)) u_dut (
        .clk(clk), .rst(rst), .mem_address(addr), .mem_read(rd), .mem_write(wr),
        .mem_byte_enable(be), .mem_wdata(wd), .mem_rdata(rdata), .mem_resp(resp), .mem_err(err)
    );

    mp2_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .mem_address(addr1), .mem_read(rd1), .mem_write(wr1),
        .mem_byte_enable(be1), .mem_wdata(wd1), .mem_rdata(rdata1), .mem_resp(resp1), .mem_err(err1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Cycles from now until mem_resp is seen (bounded); samples 1ns after each edge.
    task automatic wait_resp(output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!resp && n < 20);
        if (!resp) chk("resp_timeout", 32'(n), 32'(0));
    endtask

    // Full transaction: request in cycle 0, held through RESP, dropped in the following cycle.
    task automatic xact(input logic r, input logic w, input logic [31:0] a, input logic [3:0] b,
                        input logic [31:0] d, output int n, output logic [31:0] q, output logic e);
        @(negedge clk);
        rd = r; wr = w; addr = a; be = b; wd = d;
        wait_resp(n);
        q = rdata;
        e = err;
        @(posedge clk); #1;
        chk("resp_one_cycle", {31'b0, resp}, 32'd0);
        rd = 1'b0; wr = 1'b0;
    endtask

    int          n, n2, hits;
    logic [31:0] q;
    logic        e;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_resp", {31'b0, resp}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_rdata", rdata, 32'h0);

        // basic write then read
        xact(1'b0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, n, q, e);
        chk("sw_lat", 32'(n), 32'd3);
        chk("sw_err", {31'b0, e}, 32'd0);
        xact(1'b1, 1'b0, 32'h10, 4'h0, 32'h0, n, q, e);
        chk("lw_lat", 32'(n), 32'd3);
        chk("lw_data", q, 32'hDEADBEEF);

        // byte / half merges
        xact(1'b0, 1'b1, 32'h20, 4'hF, 32'h11223344, n, q, e);
        xact(1'b0, 1'b1, 32'h20, 4'h4, 32'h00AA0000, n, q, e);
        xact(1'b0, 1'b1, 32'h20, 4'h3, 32'h00005566, n, q, e);
        xact(1'b1, 1'b0, 32'h20, 4'h0, 32'h0, n, q, e);
        chk("merge_data", q, 32'h11AA5566);
        xact(1'b1, 1'b0, 32'h22, 4'h0, 32'h0, n, q, e);
        chk("unaligned_data", q, 32'h11AA5566);

        // no second transaction after a held request
        hits = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (resp) hits++;
        end
        chk("hold_no_extra", 32'(hits), 32'd0);

        // LATENCY=1 instance, write then back-to-back read
        @(negedge clk);
        wr1 = 1'b1; addr1 = 32'h10; be1 = 4'hF; wd1 = 32'hCAFEF00D;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!resp1 && n < 20);
        chk("l1_sw_lat", 32'(n), 32'd1);
        @(posedge clk); #1;
        chk("l1_resp_one_cycle", {31'b0, resp1}, 32'd0);
        wr1 = 1'b0; rd1 = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!resp1 && n < 20);
        chk("l1_lw_lat", 32'(n), 32'd1);
        chk("l1_lw_data", rdata1, 32'hCAFEF00D);
        @(posedge clk); #1;
        chk("l1_hold_no_extra", {31'b0, resp1}, 32'd0);
        rd1 = 1'b0;

        // address change during WAIT is ignored
        @(negedge clk);
        rd = 1'b1; addr = 32'h10;
        @(posedge clk); #1;
        addr = 32'h30;
        wait_resp(n);
        chk("midop_lat", 32'(n), 32'd2);
        chk("midop_data", rdata, 32'hDEADBEEF);
        @(posedge clk); #1;
        rd = 1'b0;

        // reset during WAIT abandons the transaction
        @(negedge clk);
        rd = 1'b1; addr = 32'h10;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; rd = 1'b0;
        chk("midrst_resp", {31'b0, resp}, 32'd0);
        chk("midrst_rdata", rdata, 32'h0);
        hits = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (resp) hits++;
        end
        chk("midrst_no_resp", 32'(hits), 32'd0);
        xact(1'b1, 1'b0, 32'h10, 4'h0, 32'h0, n, q, e);
        chk("midrst_keep", q, 32'hDEADBEEF);

        // out of range
        xact(1'b1, 1'b0, 32'h1000, 4'h0, 32'h0, n, q, e);
        chk("oor_rd_data", q, 32'h0);
        chk("oor_rd_err", {31'b0, e}, 32'd1);
        xact(1'b0, 1'b1, 32'h0, 4'hF, 32'h01020304, n, q, e);
        xact(1'b0, 1'b1, 32'h1000, 4'hF, 32'hFFFFFFFF, n, q, e);
        chk("oor_wr_err", {31'b0, e}, 32'd1);
        xact(1'b1, 1'b0, 32'h0, 4'h0, 32'h0, n, q, e);
        chk("oor_wr_dropped", q, 32'h01020304);
        chk("inrange_err", {31'b0, e}, 32'd0);

        // read+write conflict acts as write
        xact(1'b1, 1'b1, 32'h40, 4'hF, 32'h12345678, n, q, e);
        chk("rw_err", {31'b0, e}, 32'd1);
        chk("rw_rdata_held", q, 32'h01020304);
        xact(1'b1, 1'b0, 32'h40, 4'h0, 32'h0, n, q, e);
        chk("rw_written", q, 32'h12345678);

        // zero byte enable
        xact(1'b0, 1'b1, 32'h40, 4'h0, 32'hAAAAAAAA, n, q, e);
        chk("be0_err", {31'b0, e}, 32'd0);
        chk("be0_lat", 32'(n), 32'd3);
        xact(1'b1, 1'b0, 32'h40, 4'h0, 32'h0, n, q, e);
        chk("be0_unchanged", q, 32'h12345678);

        // back-to-back reads: resp in cycles 3 and 7
        @(negedge clk);
        rd = 1'b1; addr = 32'h10;
        wait_resp(n);
        chk("b2b_first_lat", 32'(n), 32'd3);
        chk("b2b_first_data", rdata, 32'hDEADBEEF);
        @(posedge clk); #1;
        chk("b2b_gap", {31'b0, resp}, 32'd0);
        addr = 32'h20;
        wait_resp(n2);
        chk("b2b_second_cycle", 32'(n + 1 + n2), 32'd7);
        chk("b2b_second_data", rdata, 32'h11AA5566);
        @(posedge clk); #1;
        rd = 1'b0;

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
